// File: rtl/uart_tx_controller_pkg.sv
// Shared constants for the PC serial link (also used by the opcode receiver decode)
// and the state encoding of the host-bound packet framer.
package uart_tx_controller_pkg;

    localparam logic [7:0] DEFAULT_SYNC_CHAR = 8'h24;
    localparam logic [7:0] DEFAULT_ACK_TYPE  = 8'h41;
    localparam logic [7:0] DEFAULT_DATA_TYPE = 8'h44;

    localparam int FIFO_DEPTH = 16;

    typedef enum logic [3:0] {
        IDLE,
        A_SYNC,
        A_TYPE,
        A_CODE,
        A_SUM,
        D_SYNC,
        D_TYPE,
        D_WAIT,
        D_LO,
        D_HI,
        D_SUM
    } tx_state_t;

    function automatic logic [7:0] word_byte(input logic [15:0] word, input logic high);
        return high ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_controller_if.sv
// Host-side request bundle: acknowledge strobe and the pixel word valid/ready stream.
interface uart_tx_controller_if;

    logic        ackStrobe;
    logic [7:0]  ackCode;
    logic        pixValid;
    logic [15:0] pixData;
    logic        pixLast;
    logic        pixReady;

    modport master (
        output ackStrobe, ackCode, pixValid, pixData, pixLast,
        input  pixReady
    );

    modport slave (
        input  ackStrobe, ackCode, pixValid, pixData, pixLast,
        output pixReady
    );

endinterface

// File: rtl/uart_tx_controller_uart_tx6.sv
// Serial transmitter with a 16-byte FIFO: 8N1 framing, one bit per 16 baud enables.
// buffer_reset is synchronous and flushes both the FIFO and any byte in flight.
module uart_tx6
    import uart_tx_controller_pkg::*;
(
    input  logic       clk,
    input  logic       buffer_reset,
    input  logic       en_16_x_baud,
    input  logic [7:0] data_in,
    input  logic       buffer_write,
    output logic       buffer_full,
    output logic       serial_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             tx_active;
    logic [8:0]       shift;
    logic [3:0]       tick;
    logic [3:0]       bit_idx;
    logic             push;
    logic             pop;

    assign buffer_full = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign push        = buffer_write && !buffer_full && !buffer_reset;
    assign pop         = !tx_active && (count != '0) && !buffer_reset;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // shift holds the data bits still to go plus the stop bit; the start bit is driven on load
    always_ff @(posedge clk) begin
        if (buffer_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_active  <= 1'b0;
            shift      <= '1;
            tick       <= '0;
            bit_idx    <= '0;
            serial_out <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            if (pop) begin
                shift      <= {1'b1, mem[rd_ptr]};
                rd_ptr     <= rd_ptr + 1'b1;
                tx_active  <= 1'b1;
                tick       <= '0;
                bit_idx    <= '0;
                serial_out <= 1'b0;
            end else if (tx_active && en_16_x_baud) begin
                tick <= tick + 1'b1;
                if (tick == 4'd15) begin
                    if (bit_idx == 4'd9) begin
                        tx_active  <= 1'b0;
                        serial_out <= 1'b1;
                    end else begin
                        serial_out <= shift[0];
                        shift      <= {1'b1, shift[8:1]};
                        bit_idx    <= bit_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// Frames acknowledge and pixel-word packets (SYNC, TYPE, payload, XOR checksum)
// and feeds them byte by byte into uart_tx6 towards the PC.
module uart_tx_controller
    import uart_tx_controller_pkg::*;
#(
    parameter logic [7:0] SYNC_CHAR = DEFAULT_SYNC_CHAR,
    parameter logic [7:0] ACK_TYPE  = DEFAULT_ACK_TYPE,
    parameter logic [7:0] DATA_TYPE = DEFAULT_DATA_TYPE
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  en_16_x_baud,
    output logic                  uart_tx,
    uart_tx_controller_if.slave   host,
    output logic                  busy,
    output logic [15:0]           wordCount,
    output logic                  ackOverrun
);

    tx_state_t   state;
    tx_state_t   next_state;
    logic        pending_valid;
    logic [7:0]  pending_code;
    logic [15:0] cap_data;
    logic        cap_last;
    logic [7:0]  checksum;
    logic        last_write;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        tx_buffer_full;
    logic        can_write;
    logic        clear_pending;
    logic        capture;
    logic        start_data;

    // The FIFO full flag lags a write by a cycle, so back-to-back writes are never issued
    assign can_write     = !tx_buffer_full && !last_write;
    assign clear_pending = (state == A_SUM) && tx_write;
    assign capture       = (state == D_WAIT) && host.pixValid;
    assign start_data    = (state == IDLE) && !pending_valid && host.pixValid;
    assign busy          = (state != IDLE) || pending_valid;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        tx_write      = 1'b0;
        tx_data       = 8'h00;
        host.pixReady = 1'b0;
        case (state)
            IDLE: begin
                if (pending_valid) begin
                    next_state = A_SYNC;
                end else if (host.pixValid) begin
                    next_state = D_SYNC;
                end
            end
            A_SYNC: begin
                tx_data  = SYNC_CHAR;
                tx_write = can_write;
                if (can_write) next_state = A_TYPE;
            end
            A_TYPE: begin
                tx_data  = ACK_TYPE;
                tx_write = can_write;
                if (can_write) next_state = A_CODE;
            end
            A_CODE: begin
                tx_data  = pending_code;
                tx_write = can_write;
                if (can_write) next_state = A_SUM;
            end
            A_SUM: begin
                tx_data  = checksum;
                tx_write = can_write;
                if (can_write) next_state = IDLE;
            end
            D_SYNC: begin
                tx_data  = SYNC_CHAR;
                tx_write = can_write;
                if (can_write) next_state = D_TYPE;
            end
            D_TYPE: begin
                tx_data  = DATA_TYPE;
                tx_write = can_write;
                if (can_write) next_state = D_WAIT;
            end
            D_WAIT: begin
                host.pixReady = 1'b1;
                if (host.pixValid) next_state = D_LO;
            end
            D_LO: begin
                tx_data  = word_byte(cap_data, 1'b0);
                tx_write = can_write;
                if (can_write) next_state = D_HI;
            end
            D_HI: begin
                tx_data  = word_byte(cap_data, 1'b1);
                tx_write = can_write;
                if (can_write) next_state = cap_last ? D_SUM : D_WAIT;
            end
            D_SUM: begin
                tx_data  = checksum;
                tx_write = can_write;
                if (can_write) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Checksum tracks the bytes actually written, so a late ack overwrite cannot corrupt a packet
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending_valid <= 1'b0;
            pending_code  <= '0;
            ackOverrun    <= 1'b0;
            cap_data      <= '0;
            cap_last      <= 1'b0;
            checksum      <= '0;
            wordCount     <= '0;
            last_write    <= 1'b0;
        end else begin
            last_write <= tx_write;
            if (host.ackStrobe) begin
                pending_code  <= host.ackCode;
                pending_valid <= 1'b1;
                if (pending_valid && !clear_pending) begin
                    ackOverrun <= 1'b1;
                end
            end else if (clear_pending) begin
                pending_valid <= 1'b0;
            end
            if (capture) begin
                cap_data <= host.pixData;
                cap_last <= host.pixLast;
            end
            if (tx_write) begin
                case (state)
                    A_TYPE, D_TYPE:     checksum <= tx_data;
                    A_CODE, D_LO, D_HI: checksum <= checksum ^ tx_data;
                    default:            ;
                endcase
            end
            if (start_data) begin
                wordCount <= '0;
            end else if (tx_write && (state == D_HI)) begin
                wordCount <= wordCount + 16'd1;
            end
        end
    end

    uart_tx6 u_uart_tx6 (
        .clk          (clk),
        .buffer_reset (~resetN),
        .en_16_x_baud (en_16_x_baud),
        .data_in      (tx_data),
        .buffer_write (tx_write),
        .buffer_full  (tx_buffer_full),
        .serial_out   (uart_tx)
    );

endmodule
